// File: rtl/uart_tank_frame_decoder.sv
// Opponent-tank frame parser: SYNC, x/y/dir payload, optional XOR checksum.
// Define TANK_FRAME_CHECKSUM_EN for the 5-byte checksummed frame; default is the 4-byte frame.
module uart_tank_frame_decoder #(
    parameter int         XMAX           = 799,
    parameter int         YMAX           = 599,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [9:0] xpos_tank_op,
    output logic [9:0] ypos_tank_op,
    output logic [1:0] direction_tank_uart_out,
    output logic       frame_valid,
    output logic       frame_err,
    output logic [7:0] err_count
);

    localparam logic [9:0]  XMAX_L = XMAX[9:0];
    localparam logic [9:0]  YMAX_L = YMAX[9:0];
    localparam logic [19:0] TMO_L  = TIMEOUT_CYCLES[19:0];

`ifdef TANK_FRAME_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET1   = 3'd1,
        GET2   = 3'd2,
        GET3   = 3'd3,
        GETCHK = 3'd4
    } state_t;
    localparam state_t LAST_STATE = GETCHK;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GET1 = 3'd1,
        GET2 = 3'd2,
        GET3 = 3'd3
    } state_t;
    localparam state_t LAST_STATE = GET3;
`endif

    state_t      state_q;
    logic [7:0]  b1_q;
    logic [7:0]  b2_q;
`ifdef TANK_FRAME_CHECKSUM_EN
    logic [7:0]  b3_q;
`endif
    logic [19:0] tmo_q;
    logic [9:0]  xpos_q;
    logic [9:0]  ypos_q;
    logic [1:0]  dir_q;
    logic        frame_valid_q;
    logic        frame_err_q;
    logic [7:0]  err_count_q;

    logic [7:0]  b3_s;
    logic        chk_ok_s;
    logic [9:0]  xpos_d;
    logic [9:0]  ypos_d;
    logic [1:0]  dir_d;
    logic        frame_ok_d;
    logic        done_s;
    logic        tmo_hit_s;
    logic        err_event_s;

    // Decode the candidate frame from shadow bytes plus the completing byte.
    always_comb begin
`ifdef TANK_FRAME_CHECKSUM_EN
        b3_s     = b3_q;
        chk_ok_s = (rx_data == (b1_q ^ b2_q ^ b3_q));
`else
        b3_s     = rx_data;
        chk_ok_s = 1'b1;
`endif
        xpos_d     = {b1_q, b2_q[7:6]};
        ypos_d     = {b2_q[5:0], b3_s[7:4]};
        dir_d      = b3_s[1:0];
        frame_ok_d = (b3_s[3:2] == 2'b00) && (xpos_d <= XMAX_L) &&
                     (ypos_d <= YMAX_L) && chk_ok_s;
        done_s      = rx_done && (state_q == LAST_STATE);
        // A byte arriving in the expiry cycle takes priority over the timeout.
        tmo_hit_s   = !rx_done && (state_q != IDLE) && (tmo_q == TMO_L);
        err_event_s = tmo_hit_s || (done_s && !frame_ok_d);
    end

    // Frame FSM, shadow registers, timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            b1_q          <= 8'd0;
            b2_q          <= 8'd0;
`ifdef TANK_FRAME_CHECKSUM_EN
            b3_q          <= 8'd0;
`endif
            tmo_q         <= 20'd0;
            xpos_q        <= 10'd0;
            ypos_q        <= 10'd0;
            dir_q         <= 2'd0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_count_q   <= 8'd0;
        end else begin
            frame_valid_q <= done_s && frame_ok_d;
            frame_err_q   <= err_event_s;
            if (err_event_s && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end else begin
                err_count_q <= err_count_q;
            end

            if (rx_done || (state_q == IDLE) || tmo_hit_s) begin
                tmo_q <= 20'd0;
            end else begin
                tmo_q <= tmo_q + 20'd1;
            end

            if (done_s && frame_ok_d) begin
                xpos_q <= xpos_d;
                ypos_q <= ypos_d;
                dir_q  <= dir_d;
            end else begin
                xpos_q <= xpos_q;
                ypos_q <= ypos_q;
                dir_q  <= dir_q;
            end

            if (tmo_hit_s) begin
                state_q <= IDLE;
                b1_q    <= 8'd0;
                b2_q    <= 8'd0;
`ifdef TANK_FRAME_CHECKSUM_EN
                b3_q    <= 8'd0;
`endif
            end else if (rx_done) begin
                case (state_q)
                    IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            state_q <= GET1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    GET1: begin
                        b1_q    <= rx_data;
                        state_q <= GET2;
                    end
                    GET2: begin
                        b2_q    <= rx_data;
                        state_q <= GET3;
                    end
`ifdef TANK_FRAME_CHECKSUM_EN
                    GET3: begin
                        b3_q    <= rx_data;
                        state_q <= GETCHK;
                    end
                    GETCHK: begin
                        state_q <= IDLE;
                    end
`else
                    GET3: begin
                        state_q <= IDLE;
                    end
`endif
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end else begin
                state_q <= state_q;
            end
        end
    end

    assign xpos_tank_op            = xpos_q;
    assign ypos_tank_op            = ypos_q;
    assign direction_tank_uart_out = dir_q;
    assign frame_valid             = frame_valid_q;
    assign frame_err               = frame_err_q;
    assign err_count               = err_count_q;

endmodule

// File: tb/tb_uart_tank_frame_decoder.sv
// Randomized self-checking bench for uart_tank_frame_decoder against a byte-level frame model.
// Honours TANK_FRAME_CHECKSUM_EN the same way the design does.
module tb_uart_tank_frame_decoder;

    localparam int         XMAX = 799;
    localparam int         YMAX = 599;
    localparam int         TMO  = 40;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef TANK_FRAME_CHECKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [9:0] xpos_tank_op;
    logic [9:0] ypos_tank_op;
    logic [1:0] direction_tank_uart_out;
    logic       frame_valid;
    logic       frame_err;
    logic [7:0] err_count;

    uart_tank_frame_decoder #(
        .XMAX(XMAX), .YMAX(YMAX), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(SYNC)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .xpos_tank_op(xpos_tank_op), .ypos_tank_op(ypos_tank_op),
        .direction_tank_uart_out(direction_tank_uart_out),
        .frame_valid(frame_valid), .frame_err(frame_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: collects payload bytes after a sync and judges whole frames.
    bit  m_in_frame;
    int  m_buf[$];
    int  m_x, m_y, m_dir, m_cnt;
    bit  m_valid, m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0; m_buf.delete();
        m_x = 0; m_y = 0; m_dir = 0; m_cnt = 0; m_valid = 0; m_err = 0;
    endtask

    task automatic model_error();
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
    endtask

    task automatic model_byte(input int b);
        int x, y, d;
        bit ok;
        m_valid = 0; m_err = 0;
        if (!m_in_frame) begin
            if (b == int'(SYNC)) begin
                m_in_frame = 1;
                m_buf.delete();
            end
        end else begin
            m_buf.push_back(b);
            if (m_buf.size() == NB) begin
                x  = m_buf[0] * 4 + m_buf[1] / 64;
                y  = (m_buf[1] % 64) * 16 + m_buf[2] / 16;
                d  = m_buf[2] % 4;
                ok = ((m_buf[2] / 4) % 4 == 0) && (x <= XMAX) && (y <= YMAX);
`ifdef TANK_FRAME_CHECKSUM_EN
                ok = ok && (m_buf[3] == (m_buf[0] ^ m_buf[1] ^ m_buf[2]));
`endif
                if (ok) begin
                    m_x = x; m_y = y; m_dir = d; m_valid = 1;
                end else begin
                    model_error();
                end
                m_in_frame = 0;
            end
        end
    endtask

    task automatic check_all(input string pfx);
        check_eq({pfx, ".valid"}, {31'd0, frame_valid}, m_valid);
        check_eq({pfx, ".err"},   {31'd0, frame_err},   m_err);
        check_eq({pfx, ".x"},     {22'd0, xpos_tank_op}, m_x);
        check_eq({pfx, ".y"},     {22'd0, ypos_tank_op}, m_y);
        check_eq({pfx, ".dir"},   {30'd0, direction_tank_uart_out}, m_dir);
        check_eq({pfx, ".cnt"},   {24'd0, err_count}, m_cnt);
    endtask

    // Called at a negedge; leaves the bench at a negedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b; rx_done = 1'b1;
        @(posedge clk); @(negedge clk);
        rx_done = 1'b0; rx_data = 8'($urandom);
        model_byte(int'(b));
        check_all("byte");
        repeat (gap) begin
            @(posedge clk); @(negedge clk);
            m_valid = 0; m_err = 0;
            check_all("idle");
        end
    endtask

    task automatic send_frame(input int x, input int y, input int d, input int res,
                              input bit bad_chk, input int gap);
        logic [9:0] xv, yv;
        logic [7:0] b1, b2, b3, b4;
        xv = 10'(x); yv = 10'(y);
        b1 = xv[9:2];
        b2 = {xv[1:0], yv[9:4]};
        b3 = {yv[3:0], 2'(res), 2'(d)};
        b4 = b1 ^ b2 ^ b3 ^ {7'd0, bad_chk};
        send_byte(SYNC, gap);
        send_byte(b1, gap);
        send_byte(b2, gap);
        send_byte(b3, gap);
`ifdef TANK_FRAME_CHECKSUM_EN
        send_byte(b4, gap);
`endif
    endtask

    int err_seen, first_err, sat_before;

    initial begin
        rst = 1'b1; rx_done = 1'b0; rx_data = 8'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all("reset");

        // Nominal frame: x=400 y=300 dir=2
        send_byte(8'hA5, 0); send_byte(8'h64, 0); send_byte(8'h12, 0); send_byte(8'hC2, 0);
`ifdef TANK_FRAME_CHECKSUM_EN
        send_byte(8'hB4, 1);
`endif
        check_eq("nom.x", {22'd0, xpos_tank_op}, 400);
        check_eq("nom.y", {22'd0, ypos_tank_op}, 300);
        check_eq("nom.dir", {30'd0, direction_tank_uart_out}, 2);

        // Rejected frame: bad checksum, or reserved bits in the plain build
`ifdef TANK_FRAME_CHECKSUM_EN
        send_byte(8'hA5, 0); send_byte(8'h64, 0); send_byte(8'h12, 0); send_byte(8'hC2, 0);
        send_byte(8'hB5, 1);
`else
        send_byte(8'hA5, 0); send_byte(8'h64, 0); send_byte(8'h12, 0); send_byte(8'hC6, 1);
`endif
        check_eq("rej.cnt", {24'd0, err_count}, 1);
        check_eq("rej.x", {22'd0, xpos_tank_op}, 400);

        // Range reject x=800
        send_byte(8'hA5, 0); send_byte(8'hC8, 0); send_byte(8'h02, 0); send_byte(8'hC0, 0);
`ifdef TANK_FRAME_CHECKSUM_EN
        send_byte(8'h0A, 0);
`endif
        send_frame(XMAX, YMAX, 3, 0, 0, 0);
        send_frame(XMAX, YMAX + 1, 1, 0, 0, 0);

        // Timeout after two bytes
        send_byte(8'hA5, 0); send_byte(8'h64, 0);
        err_seen = 0; first_err = -1;
        for (int k = 1; k <= TMO + 3; k++) begin
            @(posedge clk); @(negedge clk);
            check_eq("tmo.valid", {31'd0, frame_valid}, 0);
            if (frame_err === 1'b1) begin
                err_seen++;
                if (first_err < 0) first_err = k;
            end
        end
        check_eq("tmo.pulses", err_seen, 1);
        check_eq("tmo.late_enough", {31'd0, first_err >= TMO - 1}, 1);
        m_in_frame = 0; m_buf.delete(); model_error(); m_err = 0;
        check_all("tmo.after");
        send_frame(123, 456, 1, 0, 0, 0);

        // Gaps right at the timeout limit: the byte wins
        send_frame(10, 20, 3, 0, 0, TMO);

        // Garbage, then a frame whose B1 equals the sync byte
        send_byte(8'h00, 0); send_byte(8'hFF, 0);
        send_frame(660, 100, 1, 0, 0, 0);
        check_eq("emb.x", {22'd0, xpos_tank_op}, 660);

        // Randomized frames with occasional faults and inter-frame garbage
        for (int i = 0; i < 150; i++) begin
            int ng, g;
            ng = $urandom_range(0, 2);
            for (int j = 0; j < ng; j++) begin
                g = $urandom_range(0, 255);
                if (g == int'(SYNC)) g = 0;
                send_byte(8'(g), $urandom_range(0, 1));
            end
            send_frame($urandom_range(0, 860), $urandom_range(0, 660), $urandom_range(0, 3),
                       ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0,
                       ($urandom_range(0, 9) == 0), $urandom_range(0, 2));
        end

        // Saturation: 300 bad frames
        sat_before = m_cnt;
        for (int i = 0; i < 300; i++) begin
            send_frame($urandom_range(0, 799), $urandom_range(0, 599), 0, 1, 0, 0);
        end
        check_eq("sat.cnt", {24'd0, err_count}, 255);

        // Reset mid-frame
        send_byte(8'hA5, 0); send_byte(8'h64, 0);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all("rst");
        @(posedge clk); @(negedge clk);
        check_all("rst.after");
        send_frame(400, 300, 2, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
